// File: rtl/axis_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// axis_uart_tx_arbiter
//
// Packet-level round-robin arbiter that shares one AXI-Stream -> FIFO -> UART
// transmit path among NUM_PORTS sources. A granted port keeps the path until
// its packet ends (source last or forced by the beat watchdog), so bytes of
// different packets never interleave on the serial line. Data passes straight
// through; nothing is buffered or dropped here.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   s_axis_data/valid/last/ready   per-port source streams (port i at
//                       s_axis_data[i*WIDTH +: WIDTH])
//   m_axis_data/valid/last/ready   stream towards the FIFO/UART TX chain
//   grant               one-hot current owner, zero when idle
//   grant_id            index of the current or most recent owner
//   busy                high while a port owns the path
//   err_trunc           one-cycle pulse after a packet was forcibly ended
// ---------------------------------------------------------------------------
module axis_uart_tx_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_PORTS*WIDTH-1:0]   s_axis_data,
    input  logic [NUM_PORTS-1:0]         s_axis_valid,
    input  logic [NUM_PORTS-1:0]         s_axis_last,
    output logic [NUM_PORTS-1:0]         s_axis_ready,
    output logic [WIDTH-1:0]             m_axis_data,
    output logic                         m_axis_valid,
    output logic                         m_axis_last,
    input  logic                         m_axis_ready,
    output logic [NUM_PORTS-1:0]         grant,
    output logic [$clog2(NUM_PORTS)-1:0] grant_id,
    output logic                         busy,
    output logic                         err_trunc
);

    localparam int IDW = $clog2(NUM_PORTS);
    localparam int CW  = $clog2(MAX_BEATS);
    localparam logic [CW-1:0]  LAST_CNT = CW'(MAX_BEATS - 1);
    localparam logic [IDW-1:0] RST_ID   = IDW'(NUM_PORTS - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t               state_r, state_nxt_s;
    logic [NUM_PORTS-1:0] grant_r, grant_nxt_s;
    logic [IDW-1:0]       grant_id_r, grant_id_nxt_s;
    logic [CW-1:0]        beat_cnt_r, beat_cnt_nxt_s;
    logic                 err_trunc_r, err_trunc_nxt_s;
    logic [IDW:0]         pick_s;
    logic                 owner_last_s;
    logic                 xfer_s;

    // Round-robin pick: {found, index} of the first requester after last_id.
    // Scanning from the lowest priority upwards lets the nearest one win.
    function automatic logic [IDW:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                             input logic [IDW-1:0]       last_id);
        logic [IDW:0]   res;
        logic [IDW-1:0] idx;
        res = {(IDW+1){1'b0}};
        for (int k = NUM_PORTS; k >= 1; k--) begin
            idx = IDW'((int'(last_id) + k) % NUM_PORTS);
            if (req[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // One-hot vector for a port index
    function automatic logic [NUM_PORTS-1:0] onehot_of(input logic [IDW-1:0] id);
        return {{(NUM_PORTS-1){1'b0}}, 1'b1} << id;
    endfunction

    // Route the owner's stream onto the TX path and return ready to it alone
    always_comb begin
        m_axis_data  = {WIDTH{1'b0}};
        m_axis_valid = 1'b0;
        owner_last_s = 1'b0;
        s_axis_ready = {NUM_PORTS{1'b0}};
        for (int i = 0; i < NUM_PORTS; i++) begin
            if ((state_r == ST_GRANT) && (grant_id_r == IDW'(i))) begin
                m_axis_data     = s_axis_data[i*WIDTH +: WIDTH];
                m_axis_valid    = s_axis_valid[i];
                owner_last_s    = s_axis_last[i];
                s_axis_ready[i] = m_axis_ready;
            end else begin
                s_axis_ready[i] = 1'b0;
            end
        end
        // Watchdog: the MAX_BEATS-th beat always closes the packet
        if (state_r == ST_GRANT) begin
            m_axis_last = owner_last_s | (beat_cnt_r == LAST_CNT);
        end else begin
            m_axis_last = 1'b0;
        end
    end

    assign xfer_s = m_axis_valid & m_axis_ready;

    // Next-state logic: arbitrate in IDLE, count beats and release in GRANT
    always_comb begin
        state_nxt_s     = state_r;
        grant_nxt_s     = grant_r;
        grant_id_nxt_s  = grant_id_r;
        beat_cnt_nxt_s  = beat_cnt_r;
        err_trunc_nxt_s = 1'b0;
        pick_s          = rr_pick(s_axis_valid, grant_id_r);
        case (state_r)
            ST_IDLE: begin
                if (pick_s[IDW]) begin
                    state_nxt_s    = ST_GRANT;
                    grant_id_nxt_s = pick_s[IDW-1:0];
                    grant_nxt_s    = onehot_of(pick_s[IDW-1:0]);
                    beat_cnt_nxt_s = {CW{1'b0}};
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (xfer_s && m_axis_last) begin
                    state_nxt_s     = ST_IDLE;
                    grant_nxt_s     = {NUM_PORTS{1'b0}};
                    beat_cnt_nxt_s  = {CW{1'b0}};
                    // Final beat without source last means the watchdog fired
                    err_trunc_nxt_s = ~owner_last_s;
                end else if (xfer_s) begin
                    beat_cnt_nxt_s = beat_cnt_r + CW'(1);
                end else begin
                    beat_cnt_nxt_s = beat_cnt_r;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                grant_nxt_s    = {NUM_PORTS{1'b0}};
                beat_cnt_nxt_s = {CW{1'b0}};
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Grant, owner index, beat counter and truncation pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_r     <= {NUM_PORTS{1'b0}};
            grant_id_r  <= RST_ID;
            beat_cnt_r  <= {CW{1'b0}};
            err_trunc_r <= 1'b0;
        end else begin
            grant_r     <= grant_nxt_s;
            grant_id_r  <= grant_id_nxt_s;
            beat_cnt_r  <= beat_cnt_nxt_s;
            err_trunc_r <= err_trunc_nxt_s;
        end
    end

    assign grant     = grant_r;
    assign grant_id  = grant_id_r;
    assign busy      = (state_r == ST_GRANT);
    assign err_trunc = err_trunc_r;

endmodule

// File: tb/tb_axis_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axis_uart_tx_arbiter
//
// Per-port source queues feed the arbiter; every beat pushed to a source also
// pushes its expected (owner, data, last, forced) entry to a scoreboard in the
// order the round-robin policy must serve it. Each transfer on the TX side
// pops and compares one entry.
// ---------------------------------------------------------------------------
module tb_axis_uart_tx_arbiter;

    localparam int NP   = 4;
    localparam int W    = 8;
    localparam int MAXB = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [NP*W-1:0] s_axis_data;
    logic [NP-1:0]   s_axis_valid;
    logic [NP-1:0]   s_axis_last;
    logic [NP-1:0]   s_axis_ready;
    logic [W-1:0]    m_axis_data;
    logic            m_axis_valid;
    logic            m_axis_last;
    logic            m_axis_ready;
    logic [NP-1:0]   grant;
    logic [1:0]      grant_id;
    logic            busy;
    logic            err_trunc;

    axis_uart_tx_arbiter #(.NUM_PORTS(NP), .WIDTH(W), .MAX_BEATS(MAXB)) dut (
        .clk(clk), .rst(rst),
        .s_axis_data(s_axis_data), .s_axis_valid(s_axis_valid),
        .s_axis_last(s_axis_last), .s_axis_ready(s_axis_ready),
        .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid),
        .m_axis_last(m_axis_last), .m_axis_ready(m_axis_ready),
        .grant(grant), .grant_id(grant_id), .busy(busy), .err_trunc(err_trunc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] port;
        logic [7:0] data;
        logic       last;
        logic       forced;
    } exp_t;

    exp_t       sb_q[$];
    logic [8:0] src_q[NP][$];   // {last, data}
    int         chk_cnt  = 0;
    int         err_cnt  = 0;
    logic       exp_err  = 1'b0;
    int         gap      = 0;
    logic       gap_pend = 1'b0;
    int         n;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Queue a packet on a source and its expected beats on the scoreboard
    task automatic send(input int port, input int nb, input logic [7:0] base, input logic with_last);
        int   cnt;
        logic sl, fl, l;
        logic [7:0] d;
        cnt = 0;
        for (int k = 0; k < nb; k++) begin
            d  = base + 8'(k);
            sl = with_last && (k == nb - 1);
            fl = !sl && (cnt == MAXB - 1);
            l  = sl | fl;
            src_q[port].push_back({sl, d});
            sb_q.push_back('{port: 2'(port), data: d, last: l, forced: fl});
            cnt = l ? 0 : cnt + 1;
        end
    endtask

    task automatic drive_src();
        for (int i = 0; i < NP; i++) begin
            if (src_q[i].size() > 0) begin
                s_axis_valid[i]      = 1'b1;
                s_axis_last[i]       = src_q[i][0][8];
                s_axis_data[i*W +: W] = src_q[i][0][7:0];
            end else begin
                s_axis_valid[i]      = 1'b0;
                s_axis_last[i]       = 1'b0;
                s_axis_data[i*W +: W] = 8'h00;
            end
        end
    endtask

    // One clock: sample at negedge, advance sources after the rising edge
    task automatic step();
        logic [NP-1:0] hs;
        exp_t e;
        @(negedge clk);
        check_eq("err_trunc", 32'(err_trunc), 32'(exp_err));
        exp_err = 1'b0;
        check_eq("ready_outside_grant", 32'(s_axis_ready & ~grant), 32'd0);
        if (gap == 2) begin
            if (gap_pend) check_eq("single_bubble_busy", 32'(busy), 32'd1);
            gap = 0;
        end else if (gap == 1) begin
            check_eq("bubble_busy", 32'(busy), 32'd0);
            check_eq("bubble_ready", 32'(s_axis_ready), 32'd0);
            gap_pend = |s_axis_valid;
            gap = 2;
        end
        if (m_axis_valid && m_axis_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_beat", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("owner", 32'(grant_id), 32'(e.port));
                check_eq("data", 32'(m_axis_data), 32'(e.data));
                check_eq("last", 32'(m_axis_last), 32'(e.last));
                if (e.last) gap = 1;
                exp_err = e.forced;
            end
        end
        hs = s_axis_valid & s_axis_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) begin
            if (hs[i]) void'(src_q[i].pop_front());
        end
        drive_src();
    endtask

    task automatic run_until_empty(output int steps, input int budget);
        steps = 0;
        while (sb_q.size() > 0 && steps < budget) begin
            step();
            steps++;
        end
        if (sb_q.size() > 0) check_eq("timeout", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NP; i++) src_q[i].delete();
        sb_q.delete();
        exp_err  = 1'b0;
        gap      = 0;
        gap_pend = 1'b0;
        m_axis_ready = 1'b1;
        drive_src();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // Reset values
        do_reset();
        #1;
        check_eq("rst_grant", 32'(grant), 32'd0);
        check_eq("rst_grant_id", 32'(grant_id), 32'd3);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_err", 32'(err_trunc), 32'd0);
        check_eq("rst_ready", 32'(s_axis_ready), 32'd0);
        check_eq("rst_mvalid", 32'(m_axis_valid), 32'd0);
        check_eq("rst_mlast", 32'(m_axis_last), 32'd0);
        check_eq("rst_mdata", 32'(m_axis_data), 32'd0);

        // Single source, port 2
        do_reset();
        send(2, 3, 8'hA1, 1'b1);
        drive_src();
        check_eq("p2_pre_grant", 32'(grant), 32'd0);
        step();
        check_eq("p2_grant", 32'(grant), 32'b0100);
        check_eq("p2_grant_id", 32'(grant_id), 32'd2);
        check_eq("p2_busy", 32'(busy), 32'd1);
        run_until_empty(n, 50);
        check_eq("p2_consecutive", 32'(n), 32'd3);
        check_eq("p2_idle_grant", 32'(grant), 32'd0);
        check_eq("p2_idle_busy", 32'(busy), 32'd0);

        // Contention: 0, 1, 3 at once
        do_reset();
        send(0, 2, 8'h10, 1'b1);
        send(1, 2, 8'h20, 1'b1);
        send(3, 2, 8'h30, 1'b1);
        drive_src();
        run_until_empty(n, 100);
        check_eq("contention_cycles", 32'(n), 32'd9);

        // Fairness: port 0 continuous, port 1 once
        do_reset();
        send(0, 2, 8'h40, 1'b1);
        send(1, 1, 8'h50, 1'b1);
        send(0, 2, 8'h44, 1'b1);
        drive_src();
        run_until_empty(n, 100);
        check_eq("fairness_cycles", 32'(n), 32'd8);

        // Backpressure on a 4-byte packet from port 1, port 2 waiting
        do_reset();
        send(1, 4, 8'hB0, 1'b1);
        send(2, 1, 8'hC0, 1'b1);
        drive_src();
        n = 0;
        while (sb_q.size() > 0 && n < 40) begin
            m_axis_ready = (n == 2 || n == 3) ? 1'b0 : 1'b1;
            #1;
            if (n == 2 || n == 3) begin
                check_eq("bp_ready_low", 32'(s_axis_ready), 32'd0);
                check_eq("bp_valid_held", 32'(m_axis_valid), 32'd1);
                check_eq("bp_owner", 32'(grant), 32'b0010);
            end
            step();
            n++;
        end
        if (sb_q.size() > 0) check_eq("timeout", 32'(sb_q.size()), 32'd0);
        check_eq("bp_cycles", 32'(n), 32'd9);

        // Truncation: 20 beats without last, with a stall inside the packet
        do_reset();
        send(3, 20, 8'h60, 1'b0);
        drive_src();
        n = 0;
        while (sb_q.size() > 0 && n < 100) begin
            m_axis_ready = (n >= 5 && n <= 7) ? 1'b0 : 1'b1;
            step();
            n++;
        end
        if (sb_q.size() > 0) check_eq("timeout", 32'(sb_q.size()), 32'd0);
        check_eq("trunc_cycles", 32'(n), 32'd25);
        step();
        check_eq("trunc_hold_grant", 32'(grant), 32'b1000);
        check_eq("trunc_hold_valid", 32'(m_axis_valid), 32'd0);

        // Reset during beat 2 of a 5-beat packet from port 0
        do_reset();
        send(0, 5, 8'hD0, 1'b1);
        drive_src();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("mid_rst_grant", 32'(grant), 32'd0);
        check_eq("mid_rst_grant_id", 32'(grant_id), 32'd3);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        #1;
        check_eq("mid_rst_ready", 32'(s_axis_ready), 32'd0);
        check_eq("mid_rst_mvalid", 32'(m_axis_valid), 32'd0);
        send(1, 2, 8'hE0, 1'b1);
        drive_src();
        run_until_empty(n, 50);
        check_eq("post_rst_cycles", 32'(n), 32'd7);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
